// File: rtl/xorshift_pkg.sv
// Shared constants for the xorshift RNG block: datapath width, default seed, FSM encoding.
// No logic; imported by the arbiter top and the shifter.
package xorshift_pkg;

  localparam int XS_WIDTH = 32;
  localparam logic [XS_WIDTH-1:0] XS_DEFAULT_SEED = 32'd20240301;

  localparam logic [0:0] ST_WARMUP = 1'b0;
  localparam logic [0:0] ST_RUN    = 1'b1;

endpackage

// File: rtl/XORShifter.sv
// One 32-bit xorshift step (13/17/5), purely combinational, zero latency.
// No handshake; output follows input in the same cycle.
module XORShifter
  import xorshift_pkg::*;
(
  input  logic [XS_WIDTH-1:0] din,
  output logic [XS_WIDTH-1:0] dout
);

  logic [XS_WIDTH-1:0] s1;
  logic [XS_WIDTH-1:0] s2;

  assign s1   = din ^ (din << 13);
  assign s2   = s1 ^ (s1 >> 17);
  assign dout = s2 ^ (s2 << 5);

endmodule

// File: rtl/rr_arbiter_onehot.sv
// Round-robin search from rr_ptr upward with wrap; one-hot grant plus index, combinational.
// No state and no backpressure; the owner of rr_ptr decides when it advances.
module rr_arbiter_onehot #(
  parameter  int N  = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] rr_ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  always_comb begin
    int          pos;
    logic [IW-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    pos       = 0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= N) pos = pos - N;
      idx = IW'(pos);
      if (!grant_any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        grant_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xorshift_rng_arbiter.sv
// Shares one xorshift step between NUM_REQ requesters; grant is combinational, response one cycle later.
// Consumers cannot stall; requesters are held off during warm-up and on a seed load.
module xorshift_rng_arbiter
  import xorshift_pkg::*;
#(
  parameter int                  NUM_REQ      = 4,
  parameter logic [XS_WIDTH-1:0] SEED_DEFAULT = XS_DEFAULT_SEED,
  parameter int                  WARMUP_STEPS = 4,
  parameter int                  COUNT_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                seed_load,
  input  logic [XS_WIDTH-1:0] seed_value,
  input  logic [NUM_REQ-1:0]  req_valid,
  output logic [NUM_REQ-1:0]  req_ready,
  output logic [NUM_REQ-1:0]  rsp_valid,
  output logic [XS_WIDTH-1:0] rsp_data,
  output logic                busy,
  output logic [COUNT_W-1:0]  draw_count
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int WW = (WARMUP_STEPS > 1) ? $clog2(WARMUP_STEPS) : 1;
  localparam logic [WW-1:0] WARM_LAST = WW'((WARMUP_STEPS > 0) ? WARMUP_STEPS - 1 : 0);
  localparam logic [IW-1:0] PTR_LAST  = IW'(NUM_REQ - 1);
  // With no warm-up configured, reset and seed loads land straight in RUN.
  localparam logic [0:0]    ST_START  = (WARMUP_STEPS == 0) ? ST_RUN : ST_WARMUP;

  logic [XS_WIDTH-1:0] state;
  logic [XS_WIDTH-1:0] next_state;
  logic [XS_WIDTH-1:0] seed_eff;
  logic [0:0]          fsm;
  logic [WW-1:0]       warm_cnt;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       grant_idx;
  logic [NUM_REQ-1:0]  grant;
  logic                grant_any;
  logic                can_grant;
  logic                draw;

  XORShifter u_xs (
    .din  (state),
    .dout (next_state)
  );

  rr_arbiter_onehot #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign busy      = (fsm == ST_WARMUP);
  assign can_grant = (fsm == ST_RUN) && !seed_load && !rst;
  assign req_ready = can_grant ? grant : '0;
  assign draw      = can_grant && grant_any;
  // A zero seed would lock xorshift at zero forever.
  assign seed_eff  = (seed_value == '0) ? SEED_DEFAULT : seed_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEED_DEFAULT;
      fsm        <= ST_START;
      warm_cnt   <= '0;
      rr_ptr     <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      draw_count <= '0;
    end else begin
      rsp_valid <= '0;
      if (seed_load) begin
        state    <= seed_eff;
        warm_cnt <= '0;
        fsm      <= ST_START;
      end else if (fsm == ST_WARMUP) begin
        state <= next_state;
        if (warm_cnt == WARM_LAST) begin
          fsm      <= ST_RUN;
          warm_cnt <= '0;
        end else begin
          warm_cnt <= warm_cnt + 1'b1;
        end
      end else if (draw) begin
        state      <= next_state;
        rsp_data   <= next_state;
        rsp_valid  <= grant;
        rr_ptr     <= (grant_idx == PTR_LAST) ? '0 : grant_idx + 1'b1;
        draw_count <= draw_count + 1'b1;
      end
    end
  end

endmodule
